// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
//   Request / write-back bundle between the issue logic and muldiv_unit.
//
//   Handshake: start is a one-cycle request. It is taken only on a rising
//   clk edge where busy is low and kill is low. While busy is high, start is
//   ignored and the caller must hold off issue. done pulses for one cycle
//   when a result is presented on rd_addr/reg_data. wren is done qualified
//   by rd_addr != 0. There is no back-pressure on the write-back side.
//
//   Signals (master = issue side, slave = muldiv_unit):
//     start     request, accepted only while idle
//     kill      synchronous abort of the operation in flight
//     funct3    0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//     op_a      rs1 value
//     op_b      rs2 value
//     rd_in     destination register
//     busy      high while an operation is in flight or completing
//     done      one-cycle completion pulse
//     wren      register-file write enable
//     rd_addr   destination of the last completed operation
//     reg_data  result of the last completed operation
//     state_dbg FSM state, for observation only
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            wren;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] reg_data;
  logic [1:0]      state_dbg;

  modport master (
    output start, kill, funct3, op_a, op_b, rd_in,
    input  busy, done, wren, rd_addr, reg_data, state_dbg
  );

  modport slave (
    input  start, kill, funct3, op_a, op_b, rd_in,
    output busy, done, wren, rd_addr, reg_data, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit. One bit of shift-add multiply or
//   restoring divide per clock on operand magnitudes; the result sign is
//   applied on the final iteration. Divide-by-zero and signed overflow are
//   resolved at issue and complete on the next cycle.
//
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    muldiv_unit_if.slave: start/kill/funct3/op_a/op_b/rd_in in,
//            busy/done/wren/rd_addr/reg_data/state_dbg out
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic                neg_q;
  // Multiply: acc_q is the running product, a_sh_q the left-shifting
  // multiplicand, b_q the right-shifting multiplier.
  // Divide: acc_q = {remainder, dividend shifting into quotient}, b_q is the
  // divisor and a_sh_q is unused.
  logic [2*XLEN-1:0]   acc_q;
  logic [2*XLEN-1:0]   a_sh_q;
  logic [XLEN-1:0]     b_q;
  logic [4:0]          rd_addr_q;
  logic [XLEN-1:0]     reg_data_q;

  // ---------------- issue-side decode (from request inputs) ----------------
  logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in, is_div_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero_in, div_ovf_in, special_in;
  logic [XLEN-1:0] special_res;
  logic            accept, last_iter;

  always_comb begin
    a_signed_in = (bus.funct3 != 3'd3) && (bus.funct3 != 3'd5) && (bus.funct3 != 3'd7);
    b_signed_in = (bus.funct3 == 3'd0) || (bus.funct3 == 3'd1) ||
                  (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    a_neg_in    = a_signed_in && bus.op_a[XLEN-1];
    b_neg_in    = b_signed_in && bus.op_b[XLEN-1];
    mag_a_in    = a_neg_in ? (-bus.op_a) : bus.op_a;
    mag_b_in    = b_neg_in ? (-bus.op_b) : bus.op_b;
    is_div_in   = bus.funct3[2];
    div_zero_in = is_div_in && (bus.op_b == '0);
    div_ovf_in  = is_div_in && !bus.funct3[0] &&
                  (bus.op_a == INT_MIN) && (bus.op_b == '1);
    special_in  = div_zero_in || div_ovf_in;
    // funct3[1] selects remainder for the divide group.
    if (div_zero_in) special_res = bus.funct3[1] ? bus.op_a : '1;
    else             special_res = bus.funct3[1] ? '0 : INT_MIN;
  end

  assign accept    = (state_q == IDLE) && bus.start && !bus.kill;
  assign last_iter = (state_q == CALC) && (count_q == CNT_W'(XLEN-1));

  // ---------------- one iteration of the datapath ----------------
  logic [2*XLEN-1:0] mul_acc_nx, div_acc_nx, acc_nx;
  logic [XLEN:0]     div_cand, div_diff;
  logic              div_fit;
  logic [XLEN-1:0]   div_rem_nx;

  always_comb begin
    mul_acc_nx = acc_q + (b_q[0] ? a_sh_q : '0);
    // Restoring step: bring the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    div_cand   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff   = div_cand - {1'b0, b_q};
    div_fit    = !div_diff[XLEN];
    div_rem_nx = div_fit ? div_diff[XLEN-1:0] : div_cand[XLEN-1:0];
    div_acc_nx = {div_rem_nx, acc_q[XLEN-2:0], div_fit};
    acc_nx     = op_q[2] ? div_acc_nx : mul_acc_nx;
  end

  // ---------------- final sign fix-up and result select ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_val, calc_res;

  always_comb begin
    prod_s  = neg_q ? (-acc_nx) : acc_nx;
    div_val = op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    if (op_q[2])          calc_res = neg_q ? (-div_val) : div_val;
    else if (op_q == '0)  calc_res = prod_s[XLEN-1:0];
    else                  calc_res = prod_s[2*XLEN-1:XLEN];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special_in ? DONE : CALC;
      CALC: begin
        if (bus.kill)       state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- operand / accumulator registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      a_sh_q  <= '0;
      b_q     <= '0;
    end else if (accept) begin
      count_q <= '0;
      op_q    <= bus.funct3;
      rd_q    <= bus.rd_in;
      // Remainder follows the dividend; everything else is the sign xor.
      neg_q   <= (is_div_in && bus.funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
      b_q     <= mag_b_in;
      if (is_div_in) begin
        acc_q  <= {{XLEN{1'b0}}, mag_a_in};
        a_sh_q <= '0;
      end else begin
        acc_q  <= '0;
        a_sh_q <= {{XLEN{1'b0}}, mag_a_in};
      end
    end else if (state_q == CALC) begin
      count_q <= count_q + CNT_W'(1);
      acc_q   <= acc_nx;
      if (!op_q[2]) begin
        a_sh_q <= a_sh_q << 1;
        b_q    <= b_q >> 1;
      end
    end
  end

  // ---------------- write-back registers (hold until next completion) ------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      reg_data_q <= '0;
    end else if (accept && special_in) begin
      rd_addr_q  <= bus.rd_in;
      reg_data_q <= special_res;
    end else if (last_iter && !bus.kill) begin
      rd_addr_q  <= rd_q;
      reg_data_q <= calc_res;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.wren      = (state_q == DONE) && (rd_addr_q != '0);
  assign bus.rd_addr   = rd_addr_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ref_result = '0;
    case (f)
      3'd0: begin p = 64'(sa * sb); ref_result = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); ref_result = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); ref_result = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); ref_result = p[63:32]; end
      3'd4: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else begin q = sa / sb; ref_result = q[31:0]; end
      end
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_result = a;
        else begin q = sa % sb; ref_result = q[31:0]; end
      end
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
  endtask

  // Issues one request in the cycle after the next edge (cycle 0) and waits
  // for done. Returns the cycle done was seen in, or -1 after 40 cycles.
  task automatic drive_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output int lat, output logic [31:0] data,
                          output logic [4:0] rda, output logic wr,
                          output bit busy_ok);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    lat = -1; data = '0; rda = '0; wr = 1'b0; busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = cyc; data = bus.reg_data; rda = bus.rd_addr; wr = bus.wren;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.wren, bus.rd_addr, bus.reg_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b wren=%b rd=%0d data=%h, want all 0",
               bus.busy, bus.done, bus.wren, bus.rd_addr, bus.reg_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_arith();
    logic [2:0]  tf[16];
    logic [31:0] ta[16], tb[16];
    logic [31:0] a, b, exp_v;
    logic [2:0]  f;
    logic [4:0]  rd, rda;
    logic [31:0] data;
    logic        wr;
    bit          bok;
    int          lat, elat;
    tf = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
           3'd5, 3'd6, 3'd4, 3'd6, 3'd7, 3'd4, 3'd1, 3'd2};
    ta = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
           32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000,
           32'h8000_0000, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    tb = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7,
           32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1,
           32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 56; i++) begin
      if (i < 16) begin
        f = tf[i]; a = ta[i]; b = tb[i]; rd = (i == 0) ? 5'd5 : 5'(i + 1);
      end else begin
        f  = 3'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
          0:       a = 32'h8000_0000;
          1:       a = 32'hFFFF_FFFF;
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 6))
          0:       b = 32'd0;
          1:       b = 32'hFFFF_FFFF;
          2:       b = 32'($urandom_range(1, 15));
          default: b = $urandom;
        endcase
      end
      exp_q.push_back(ref_result(f, a, b));
      elat = ref_latency(f, a, b);
      drive_op(f, a, b, rd, lat, data, rda, wr, bok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (lat !== elat) begin
        n_fail++;
        $display("FAIL op%0d_latency: f=%0d a=%h b=%h done at cycle %0d want %0d",
                 i, f, a, b, lat, elat);
      end
      n_checks++;
      if (data !== exp_v) begin
        n_fail++;
        $display("FAIL op%0d_result: f=%0d a=%h b=%h got %h want %h", i, f, a, b, data, exp_v);
      end
      n_checks++;
      if (rda !== rd || wr !== (rd != 0)) begin
        n_fail++;
        $display("FAIL op%0d_writeback: got rd=%0d wren=%b want rd=%0d wren=%b",
                 i, rda, wr, rd, (rd != 0));
      end
      n_checks++;
      if (!bok) begin
        n_fail++; $display("FAIL op%0d_busy: busy dropped before done, want high", i);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] data;
    logic [4:0]  rda;
    logic        wr;
    bit          bok;
    int          lat;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.wren, bus.rd_addr, bus.reg_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_mid_calc: got busy=%b done=%b wren=%b rd=%0d data=%h, want all 0",
               bus.busy, bus.done, bus.wren, bus.rd_addr, bus.reg_data);
    end
    #2;
    rst_n = 1'b1;
    exp_q.push_back(ref_result(3'd0, 32'd7, 32'd6));
    drive_op(3'd0, 32'd7, 32'd6, 5'd5, lat, data, rda, wr, bok);
    n_checks++;
    if (lat !== 33 || data !== exp_q.pop_front() || rda !== 5'd5 || wr !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_mul: got cycle=%0d data=%h rd=%0d wren=%b want 33/0000002a/5/1",
               lat, data, rda, wr);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] exp_v;
    exp_v = ref_result(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd1; bus.op_a = 32'h1234_5678;
    bus.op_b = 32'h9ABC_DEF0; bus.rd_in = 5'd12;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (cyc == 5 || cyc == 33) begin
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = $urandom;
        bus.op_b = 32'd3; bus.rd_in = 5'd20;
      end
      if (cyc == 33) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.reg_data !== exp_v || bus.rd_addr !== 5'd12) begin
          n_fail++;
          $display("FAIL ignored_start_result: got done=%b data=%h rd=%0d want 1/%h/12",
                   bus.done, bus.reg_data, bus.rd_addr, exp_v);
        end
      end
      if (cyc == 34) begin
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL start_in_done_ignored: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_kill();
    logic [31:0] prev_data;
    logic [4:0]  prev_rd;
    bit          saw_done;
    prev_data = bus.reg_data;
    prev_rd   = bus.rd_addr;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd3; bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'd17;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wren !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_idle: got busy=%b done=%b wren=%b want 0/0/0", bus.busy, bus.done, bus.wren);
    end
    n_checks++;
    if (bus.reg_data !== prev_data || bus.rd_addr !== prev_rd) begin
      n_fail++;
      $display("FAIL kill_holds_result: got rd=%0d data=%h want rd=%0d data=%h",
               bus.rd_addr, bus.reg_data, prev_rd, prev_data);
    end
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (bus.done || bus.wren) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++; $display("FAIL kill_no_done: got done/wren pulse after kill, want none");
    end
    // kill and start together in IDLE: the request must not be taken.
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd2; bus.op_b = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL kill_over_start: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data;
    logic [4:0]  rda;
    logic        wr;
    bit          bok;
    int          lat;
    exp_q.push_back(ref_result(3'd0, 32'd3, 32'd3));
    drive_op(3'd0, 32'd3, 32'd3, 5'd0, lat, data, rda, wr, bok);
    n_checks++;
    if (lat !== 33 || data !== exp_q.pop_front() || wr !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_mul: got cycle=%0d data=%h wren=%b want 33/00000009/0", lat, data, wr);
    end
    // drive_op returns in the done cycle, so this request lands in cycle 34.
    exp_q.push_back(ref_result(3'd7, 32'd100, 32'd7));
    drive_op(3'd7, 32'd100, 32'd7, 5'd3, lat, data, rda, wr, bok);
    n_checks++;
    if (lat !== 33 || data !== exp_q.pop_front() || rda !== 5'd3 || wr !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got cycle=%0d data=%h rd=%0d wren=%b want 33/00000002/3/1",
               lat, data, rda, wr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_arith();
    test_reset_mid_op();
    test_ignore_start();
    test_kill();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
